// File: rtl/box_reset_sequencer_pkg.sv
// Shared pyon_pkg: screen limits, colours, sequencer state type and default box y-tables.
package pyon_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  localparam int unsigned Y_TABLE_DEPTH = 16;

  // Index 0 is the leftmost entry of each concatenation.
  localparam logic [0:15][6:0] Y_LEFT = {
    7'd3,  7'd13, 7'd19, 7'd22, 7'd25, 7'd31, 7'd37, 7'd49,
    7'd58, 7'd67, 7'd76, 7'd82, 7'd85, 7'd88, 7'd94, 7'd97
  };

  localparam logic [0:15][6:0] Y_RIGHT = {
    7'd7,  7'd10, 7'd16, 7'd28, 7'd34, 7'd40, 7'd43, 7'd46,
    7'd52, 7'd55, 7'd64, 7'd70, 7'd73, 7'd79, 7'd91, 7'd100
  };

endpackage

// File: rtl/box_reset_sequencer_if.sv
// Pixel valid/ready link between the reset sequencer (master) and the VGA plot arbiter (slave).
interface box_reset_sequencer_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       ready;

  modport master (output plot, x, y, colour, input ready);
  modport slave  (input plot, x, y, colour, output ready);
endinterface

// File: rtl/box_reset_sequencer_box_coord_rom.sv
// box_coord_rom: combinational (side, box) -> y base lookup, kept separate so box layouts can be swapped.
module box_coord_rom
  import pyon_pkg::*;
#(
  parameter int unsigned BOX_BITS = 4
) (
  input  logic                side,
  input  logic [BOX_BITS-1:0] box,
  output logic [6:0]          y_base
);

  logic [3:0] idx;

  always_comb begin
    idx    = 4'(box);
    y_base = side ? Y_RIGHT[idx] : Y_LEFT[idx];
  end

endmodule

// File: rtl/box_reset_sequencer.sv
// box_reset_sequencer: repaints every hazard box of every lane one pixel per accepted handshake.
// Optional BOX_RESET_PLAYER_MASK_EN adds player_mask to skip lanes.
module box_reset_sequencer
  import pyon_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned BOXES_PER_SIDE = 16,
  parameter int unsigned BOX_W          = 3,
  parameter int unsigned BOX_H          = 3,
  parameter int unsigned LEFT_X         = 38,
  parameter int unsigned RIGHT_X        = 43,
  parameter int unsigned PLAYER_PITCH   = 80,
  parameter logic [2:0]  RESET_COLOUR   = WHITE
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
`ifdef BOX_RESET_PLAYER_MASK_EN
  input  logic [NUM_PLAYERS-1:0] player_mask,
`endif
  output logic                   busy,
  output logic                   done,
  box_reset_sequencer_if.master  pix
);

  localparam int unsigned PW  = (NUM_PLAYERS > 1)    ? $clog2(NUM_PLAYERS)    : 1;
  localparam int unsigned BXW = (BOXES_PER_SIDE > 1) ? $clog2(BOXES_PER_SIDE) : 1;
  localparam int unsigned DXW = (BOX_W > 1)          ? $clog2(BOX_W)          : 1;
  localparam int unsigned DYW = (BOX_H > 1)          ? $clog2(BOX_H)          : 1;

  state_t                 state_q, state_d;
  logic [DXW-1:0]         dx_q, dx_d, adv_dx, pix_dx;
  logic [DYW-1:0]         dy_q, dy_d, adv_dy, pix_dy;
  logic [BXW-1:0]         box_q, box_d, adv_box, pix_box;
  logic                   side_q, side_d, adv_side, pix_side;
  logic [PW-1:0]          player_q, player_d, adv_player, pix_player, first_player;
  logic [NUM_PLAYERS-1:0] mask_q, mask_d, req_mask;
  logic                   plot_q, plot_d;
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [2:0]             colour_q, colour_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   adv_last;
  logic [6:0]             y_base;
  logic [8:0]             x_full, y_full;

`ifdef BOX_RESET_PLAYER_MASK_EN
  assign req_mask = player_mask;
`else
  assign req_mask = '1;
`endif

  always_comb begin
    logic found;
    found        = 1'b0;
    first_player = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (!found && req_mask[i]) begin
        first_player = PW'(i);
        found        = 1'b1;
      end
    end
  end

  // Successor of the current pixel; adv_last marks that the current pixel is the final one.
  always_comb begin
    logic found;
    found      = 1'b0;
    adv_dx     = dx_q;
    adv_dy     = dy_q;
    adv_box    = box_q;
    adv_side   = side_q;
    adv_player = player_q;
    adv_last   = 1'b0;
    if (dx_q != DXW'(BOX_W - 1)) begin
      adv_dx = dx_q + 1'b1;
    end else begin
      adv_dx = '0;
      if (dy_q != DYW'(BOX_H - 1)) begin
        adv_dy = dy_q + 1'b1;
      end else begin
        adv_dy = '0;
        if (box_q != BXW'(BOXES_PER_SIDE - 1)) begin
          adv_box = box_q + 1'b1;
        end else begin
          adv_box  = '0;
          adv_side = ~side_q;
          if (side_q) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (!found && mask_q[i] && (i > 32'(player_q))) begin
                adv_player = PW'(i);
                found      = 1'b1;
              end
            end
            adv_last = ~found;
          end
        end
      end
    end
  end

  // While plot is low the counters already hold the first pixel; afterwards we load the successor.
  assign pix_dx     = plot_q ? adv_dx     : dx_q;
  assign pix_dy     = plot_q ? adv_dy     : dy_q;
  assign pix_box    = plot_q ? adv_box    : box_q;
  assign pix_side   = plot_q ? adv_side   : side_q;
  assign pix_player = plot_q ? adv_player : player_q;

  box_coord_rom #(.BOX_BITS(BXW)) u_rom (
    .side   (pix_side),
    .box    (pix_box),
    .y_base (y_base)
  );

  assign x_full = 9'((pix_side ? RIGHT_X : LEFT_X) + 32'(pix_player) * PLAYER_PITCH + 32'(pix_dx));
  assign y_full = 9'(32'(y_base) + 32'(pix_dy));

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    box_d    = box_q;
    side_d   = side_q;
    player_d = player_q;
    mask_d   = mask_q;
    plot_d   = plot_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dx_d     = '0;
          dy_d     = '0;
          box_d    = '0;
          side_d   = 1'b0;
          player_d = first_player;
          mask_d   = req_mask;
          busy_d   = 1'b1;
          state_d  = (req_mask == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        if (!plot_q || pix.ready) begin
          if (plot_q && adv_last) begin
            state_d  = DONE;
            plot_d   = 1'b0;
            x_d      = '0;
            y_d      = '0;
            colour_d = '0;
            done_d   = 1'b1;
            dx_d     = '0;
            dy_d     = '0;
            box_d    = '0;
            side_d   = 1'b0;
            player_d = '0;
          end else begin
            plot_d   = 1'b1;
            colour_d = RESET_COLOUR;
            x_d      = x_full[7:0];
            y_d      = y_full[6:0];
            dx_d     = pix_dx;
            dy_d     = pix_dy;
            box_d    = pix_box;
            side_d   = pix_side;
            player_d = pix_player;
          end
        end
      end
      DONE: begin
        // An empty mask enters here with done low, so done still lands one cycle after the load.
        if (done_q) begin
          state_d = IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      box_q    <= '0;
      side_q   <= 1'b0;
      player_q <= '0;
      mask_q   <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      box_q    <= box_d;
      side_q   <= side_d;
      player_q <= player_d;
      mask_q   <= mask_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pix.plot   = plot_q;
  assign pix.x      = x_q;
  assign pix.y      = y_q;
  assign pix.colour = colour_q;
  assign busy       = busy_q;
  assign done       = done_q;

  a_on_screen: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == DRAW) |-> ((x_full < 9'(SCREEN_W)) && (y_full < 9'(SCREEN_H))));

endmodule
